// File: rtl/spi_word_transceiver.sv
// rtl/spi_word_transceiver.sv - SPI mode 0 slave word layer: pin synchroniser, MOSI deserialiser, MISO serialiser.
module spi_word_transceiver #(
   parameter int word_bits = 16
) (
   input  logic                 CLK,
   input  logic                 resetn,
   input  logic                 SCK,
   input  logic                 CS,
   input  logic                 MOSI,
   output logic                 MISO,
   input  logic [word_bits-1:0] word_send_data,
   output logic [word_bits-1:0] word_data_received,
   output logic                 word_received
);

   localparam int cnt_w = (word_bits > 2) ? $clog2(word_bits) : 1;
   localparam logic [cnt_w-1:0] last_bit = cnt_w'(word_bits - 1);

   logic sck_s1, sck_s2, sck_s3;
   logic cs_s1, cs_s2, cs_s3;
   logic mosi_s1, mosi_s2;

   logic [word_bits-2:0] rx_shift;
   logic [word_bits-1:0] rx_next;
   logic [word_bits-1:0] tx_shift;
   logic [word_bits-1:0] tx_next;
   logic [cnt_w-1:0]     bit_cnt;
   logic                 reload_pending;

   logic sck_rise, sck_fall, cs_fall;

   assign sck_rise = sck_s2 & ~sck_s3;
   assign sck_fall = ~sck_s2 & sck_s3;
   assign cs_fall  = ~cs_s2 & cs_s3;
   assign rx_next  = {rx_shift, mosi_s2};

   // Next tx value is computed here so MISO can be registered without lagging tx_shift.
   always_comb begin
      tx_next = tx_shift;
      if (!cs_s2) begin
         if (cs_fall)
            tx_next = word_send_data;
         else if (sck_fall)
            tx_next = reload_pending ? word_send_data : {tx_shift[word_bits-2:0], 1'b0};
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         sck_s1             <= 1'b0;
         sck_s2             <= 1'b0;
         sck_s3             <= 1'b0;
         cs_s1              <= 1'b1;
         cs_s2              <= 1'b1;
         cs_s3              <= 1'b1;
         mosi_s1            <= 1'b0;
         mosi_s2            <= 1'b0;
         rx_shift           <= '0;
         tx_shift           <= '0;
         bit_cnt            <= '0;
         reload_pending     <= 1'b0;
         word_data_received <= '0;
         word_received      <= 1'b0;
         MISO               <= 1'b0;
      end else begin
         sck_s1   <= SCK;
         sck_s2   <= sck_s1;
         sck_s3   <= sck_s2;
         cs_s1    <= CS;
         cs_s2    <= cs_s1;
         cs_s3    <= cs_s2;
         mosi_s1  <= MOSI;
         mosi_s2  <= mosi_s1;
         tx_shift <= tx_next;
         MISO     <= ~cs_s2 & tx_next[word_bits-1];

         // Deselected (including the cs_rise cycle) discards any partial word.
         if (cs_s2 || cs_fall) begin
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
         end else begin
            if (sck_rise) begin
               rx_shift <= rx_next[word_bits-2:0];
               if (bit_cnt == last_bit) begin
                  word_data_received <= rx_next;
                  word_received      <= 1'b1;
                  bit_cnt            <= '0;
                  reload_pending     <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == '0)
                     word_received <= 1'b0;
               end
            end
            if (sck_fall)
               reload_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_word_transceiver.sv
// tb/tb_spi_word_transceiver.sv - directed and randomized SPI frames against a queue-based word model.
module tb_spi_word_transceiver;

   logic        CLK = 1'b0;
   logic        resetn;
   logic        SCK;
   logic        CS;
   logic        MOSI;
   logic [15:0] wsd16;
   logic [7:0]  wsd8;
   logic        miso16, miso8;
   logic [15:0] wdr16;
   logic [7:0]  wdr8;
   logic        wr16, wr8;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   spi_word_transceiver #(.word_bits(16)) dut16 (
      .CLK(CLK), .resetn(resetn), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(miso16),
      .word_send_data(wsd16), .word_data_received(wdr16), .word_received(wr16)
   );

   spi_word_transceiver #(.word_bits(8)) dut8 (
      .CLK(CLK), .resetn(resetn), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(miso8),
      .word_send_data(wsd8), .word_data_received(wdr8), .word_received(wr8)
   );

   // Every rising edge of word_received logs the word presented with it.
   logic        wr16_d = 1'b0;
   logic [15:0] rx16_q[$];
   always @(negedge CLK) begin
      if (wr16 && !wr16_d)
         rx16_q.push_back(wdr16);
      wr16_d = wr16;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Master side of one word (or partial word): MOSI changes with SCK low, MISO sampled at the rising pin edge.
   task automatic xfer(input int nbits, input logic [15:0] mw, input bit full, input bit is8,
                       input bit do_reload, input logic [15:0] next_send,
                       output logic [15:0] mo, output bit got_rise);
      bit pre;
      mo = '0;
      got_rise = 1'b0;
      for (int i = nbits - 1; i >= 0; i--) begin
         MOSI = mw[i];
         repeat (4) @(negedge CLK);
         mo[i] = is8 ? miso8 : miso16;
         pre = is8 ? wr8 : wr16;
         SCK = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (full && i == 0 && !pre && (is8 ? wr8 : wr16))
               got_rise = 1'b1;
         end
         if (i == 0 && do_reload) begin
            if (is8) wsd8 = next_send[7:0];
            else     wsd16 = next_send;
         end
         SCK = 1'b0;
      end
   endtask

   task automatic frame_start();
      CS = 1'b0;
      repeat (8) @(negedge CLK);
   endtask

   task automatic frame_end();
      repeat (8) @(negedge CLK);
      CS = 1'b1;
      repeat (8) @(negedge CLK);
   endtask

   initial begin
      logic [15:0] mo;
      bit          gr;
      int          base;
      int          n;
      logic [15:0] w[4];
      logic [15:0] s[4];

      resetn = 1'b0;
      CS     = 1'b1;
      SCK    = 1'b0;
      MOSI   = 1'b0;
      wsd16  = 16'h0000;
      wsd8   = 8'h00;
      repeat (3) @(negedge CLK);
      chk("rst_wr", 32'(wr16), 32'h0);
      chk("rst_wdr", 32'(wdr16), 32'h0);
      chk("rst_miso", 32'(miso16), 32'h0);
      resetn = 1'b1;
      repeat (4) @(negedge CLK);

      for (int i = 0; i < 20; i++) begin
         MOSI = 1'($urandom);
         SCK  = ~SCK;
         repeat (2) @(negedge CLK);
      end
      SCK = 1'b0;
      repeat (6) @(negedge CLK);
      chk("idle_wr", 32'(wr16), 32'h0);
      chk("idle_wdr", 32'(wdr16), 32'h0);
      chk("idle_miso", 32'(miso16), 32'h0);
      chk("idle_rises", 32'(rx16_q.size()), 32'h0);

      wsd16 = 16'hA5C3;
      frame_start();
      xfer(16, 16'h1234, 1, 0, 0, 16'h0, mo, gr);
      chk("w1_miso", 32'(mo), 32'hA5C3);
      chk("w1_rise", 32'(gr), 32'h1);
      chk("w1_data", 32'(wdr16), 32'h1234);
      frame_end();

      base  = rx16_q.size();
      wsd16 = 16'hA5C3;
      frame_start();
      xfer(16, 16'hBEEF, 1, 0, 1, 16'h5555, mo, gr);
      chk("b2b0_miso", 32'(mo), 32'hA5C3);
      chk("b2b0_rise", 32'(gr), 32'h1);
      xfer(16, 16'h0001, 1, 0, 0, 16'h0, mo, gr);
      chk("b2b1_miso", 32'(mo), 32'h5555);
      chk("b2b1_rise", 32'(gr), 32'h1);
      frame_end();
      chk("b2b_count", 32'(rx16_q.size() - base), 32'h2);
      chk("b2b_word0", 32'(rx16_q[base]), 32'hBEEF);
      chk("b2b_word1", 32'(rx16_q[base + 1]), 32'h0001);

      base = rx16_q.size();
      frame_start();
      xfer(7, 16'hFFFF, 0, 0, 0, 16'h0, mo, gr);
      frame_end();
      chk("part_norise", 32'(rx16_q.size() - base), 32'h0);
      chk("part_hold", 32'(wdr16), 32'h0001);
      frame_start();
      xfer(16, 16'h8001, 1, 0, 0, 16'h0, mo, gr);
      frame_end();
      chk("part_next", 32'(wdr16), 32'h8001);
      chk("part_count", 32'(rx16_q.size() - base), 32'h1);

      wsd16 = 16'hFFFF;
      frame_start();
      xfer(9, 16'h01AB, 0, 0, 0, 16'h0, mo, gr);
      chk("mid_miso_hi", 32'(miso16), 32'h1);
      resetn = 1'b0;
      #1;
      chk("arst_wdr", 32'(wdr16), 32'h0);
      chk("arst_wr", 32'(wr16), 32'h0);
      chk("arst_miso", 32'(miso16), 32'h0);
      CS   = 1'b1;
      SCK  = 1'b0;
      MOSI = 1'b0;
      repeat (3) @(negedge CLK);
      resetn = 1'b1;
      repeat (8) @(negedge CLK);
      frame_start();
      xfer(16, 16'h00FF, 1, 0, 0, 16'h0, mo, gr);
      frame_end();
      chk("post_rst_data", 32'(wdr16), 32'h00FF);
      chk("post_rst_rise", 32'(gr), 32'h1);

      wsd8 = 8'hC3;
      frame_start();
      xfer(8, 16'h003C, 1, 1, 0, 16'h0, mo, gr);
      chk("w8_miso", 32'(mo[7:0]), 32'hC3);
      chk("w8_rise", 32'(gr), 32'h1);
      chk("w8_data", 32'(wdr8), 32'h3C);
      frame_end();

      // Random frames: every word received in order, MISO word j carries the send value current at reload j.
      for (int f = 0; f < 4; f++) begin
         n = $urandom_range(1, 3);
         for (int j = 0; j < 4; j++) begin
            w[j] = 16'($urandom);
            s[j] = 16'($urandom);
         end
         wsd16 = s[0];
         base  = rx16_q.size();
         frame_start();
         for (int j = 0; j < n; j++) begin
            xfer(16, w[j], 1, 0, (j < n - 1), s[j + 1], mo, gr);
            chk("rnd_miso", 32'(mo), 32'(s[j]));
            chk("rnd_rise", 32'(gr), 32'h1);
         end
         frame_end();
         chk("rnd_count", 32'(rx16_q.size() - base), 32'(n));
         for (int j = 0; j < n; j++)
            chk("rnd_word", 32'(rx16_q[base + j]), 32'(w[j]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
